// File: rtl/seg7_capture.sv
// Receive side of the 4-digit multiplexed 7-segment bus: rebuilds the shown hex value and dots.
// Optional feature: define SEG7_CAPTURE_DOT_EN to capture the decimal points from seg_n[7].
`timescale 1ns/1ps
module seg7_capture #(
  parameter int STABLE_CYCLES = 2,
  parameter int TIMEOUT_BITS  = 20
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  seg_n,
  input  logic [3:0]  dig,
  output logic [15:0] value,
  output logic [3:0]  dots,
  output logic        valid,
  output logic        bad,
  output logic        stale
);

`ifdef SEG7_CAPTURE_DOT_EN
  localparam int SEG_W = 8;
`else
  localparam int SEG_W = 7;
`endif
  localparam logic [3:0] STAB_M1 = 4'(STABLE_CYCLES - 1);

  function automatic logic [4:0] decode_seg(input logic [6:0] code);
    logic [4:0] res;
    case (code)
      7'h40:   res = {1'b0, 4'h0};
      7'h79:   res = {1'b0, 4'h1};
      7'h24:   res = {1'b0, 4'h2};
      7'h30:   res = {1'b0, 4'h3};
      7'h19:   res = {1'b0, 4'h4};
      7'h12:   res = {1'b0, 4'h5};
      7'h02:   res = {1'b0, 4'h6};
      7'h78:   res = {1'b0, 4'h7};
      7'h00:   res = {1'b0, 4'h8};
      7'h10:   res = {1'b0, 4'h9};
      7'h08:   res = {1'b0, 4'hA};
      7'h03:   res = {1'b0, 4'hB};
      7'h46:   res = {1'b0, 4'hC};
      7'h21:   res = {1'b0, 4'hD};
      7'h06:   res = {1'b0, 4'hE};
      7'h0E:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  logic [SEG_W-1:0]        r_seg_s1, r_seg_s2;
  logic [3:0]              r_dig_s1, r_dig_s2;
  logic [3:0]              r_stab_cnt;
  logic                    r_arm;
  logic [3:0]              r_seen;
  logic [15:0]             r_sh_nib;
  logic [3:0]              r_sh_bad;
  logic [TIMEOUT_BITS-1:0] r_to_cnt;
  logic [15:0]             r_value;
  logic                    r_valid, r_bad, r_stale;

  logic                    w_change, w_onehot, w_sample, w_publish, w_timeout;
  logic [1:0]              w_idx;
  logic [4:0]              w_dec;
  logic [3:0]              w_seen_nxt;
  logic [15:0]             w_nib_nxt;
  logic [3:0]              w_bad_nxt;
  logic [TIMEOUT_BITS-1:0] w_to_next;

  // Two-flop synchronizers; seg_n[7] only enters when dots are captured
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
      r_dig_s1 <= '0;
      r_dig_s2 <= '0;
    end else begin
      r_seg_s1 <= seg_n[SEG_W-1:0];
      r_seg_s2 <= r_seg_s1;
      r_dig_s1 <= dig;
      r_dig_s2 <= r_dig_s1;
    end
  end

  // Stage 1 holds the value stage 2 takes next, so a mismatch means the synchronized lines move this edge
  assign w_change = ({r_seg_s1, r_dig_s1} != {r_seg_s2, r_dig_s2});
  assign w_onehot = (r_dig_s2 != 4'h0) && ((r_dig_s2 & (r_dig_s2 - 4'd1)) == 4'h0);
  assign w_sample = !w_change && r_arm && w_onehot && (r_stab_cnt == STAB_M1);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stab_cnt <= '0;
      r_arm      <= 1'b1;
    end else if (w_change) begin
      r_stab_cnt <= '0;
      r_arm      <= 1'b1;
    end else begin
      if (r_stab_cnt != 4'hF) r_stab_cnt <= r_stab_cnt + 4'd1;
      if (w_sample)           r_arm      <= 1'b0;
    end
  end

  assign w_dec     = decode_seg(r_seg_s2[6:0]);
  assign w_to_next = r_to_cnt + 1'b1;
  assign w_timeout = (w_to_next == '1) && !w_sample;
  assign w_publish = (r_seen == 4'hF);

  always_comb begin
    w_idx = 2'd0;
    case (r_dig_s2)
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

`ifdef SEG7_CAPTURE_DOT_EN
  logic [3:0] r_sh_dot, r_dots, w_dot_nxt;
  assign dots = r_dots;
`else
  logic w_unused_dot;
  assign w_unused_dot = seg_n[7];
  assign dots = 4'h0;
`endif

  // Frame collection: next seen mask and shadow digits
  always_comb begin
    w_seen_nxt = r_seen;
    w_nib_nxt  = r_sh_nib;
    w_bad_nxt  = r_sh_bad;
`ifdef SEG7_CAPTURE_DOT_EN
    w_dot_nxt  = r_sh_dot;
`endif
    if (w_publish || w_timeout) w_seen_nxt = 4'h0;
    if (w_sample) begin
      // A repeated digit means we joined mid-scan: restart the frame from it
      if (w_seen_nxt[w_idx]) w_seen_nxt = 4'h0;
      w_seen_nxt[w_idx]              = 1'b1;
      w_nib_nxt[{w_idx, 2'b00} +: 4] = w_dec[3:0];
      w_bad_nxt[w_idx]               = w_dec[4];
`ifdef SEG7_CAPTURE_DOT_EN
      w_dot_nxt[w_idx]               = ~r_seg_s2[7];
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seen   <= '0;
      r_sh_nib <= '0;
      r_sh_bad <= '0;
      r_to_cnt <= '0;
`ifdef SEG7_CAPTURE_DOT_EN
      r_sh_dot <= '0;
`endif
    end else begin
      r_seen   <= w_seen_nxt;
      r_sh_nib <= w_nib_nxt;
      r_sh_bad <= w_bad_nxt;
      r_to_cnt <= w_sample ? '0 : w_to_next;
`ifdef SEG7_CAPTURE_DOT_EN
      r_sh_dot <= w_dot_nxt;
`endif
    end
  end

  // Output stage: publish the completed frame or flag a timeout
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_value <= '0;
      r_valid <= 1'b0;
      r_bad   <= 1'b0;
      r_stale <= 1'b1;
`ifdef SEG7_CAPTURE_DOT_EN
      r_dots  <= '0;
`endif
    end else begin
      r_valid <= w_publish;
      if (w_publish) begin
        r_value <= r_sh_nib;
        r_bad   <= |r_sh_bad;
        r_stale <= 1'b0;
`ifdef SEG7_CAPTURE_DOT_EN
        r_dots  <= r_sh_dot;
`endif
      end else if (w_timeout) begin
        r_stale <= 1'b1;
      end
    end
  end

  assign value = r_value;
  assign valid = r_valid;
  assign bad   = r_bad;
  assign stale = r_stale;

endmodule
